sc_collision_handler: RTL and testbench
=======================================

Name: sc_collision_handler

Overview:
- Game-control responder on the far end of the collision detector's active-low collision line.
- Samples the collision flag once per frame tick and manages a lives counter and a survival score.
- Sequences play / hit-freeze / game-over, issuing freeze, background-clear and display-blink controls to the scroller and matrix driver.
- Sits between the collision detector, the frame-rate timer and the start pushbutton, and the background scroller and matrix display path.

Parameters:
- LIVES, 3, initial lives loaded at game start (1..2^LIVES_WIDTH-1).
- LIVES_WIDTH, 2, width of lives counter.
- SCORE_WIDTH, 8, width of survival score.
- HIT_FRAMES, 4, frame ticks spent frozen/blinking after a non-fatal hit (>=1).

Ports:
- SC_COLLISION_HANDLER_CLOCK_50  in  1  system clock, all logic on rising edge.
- SC_COLLISION_HANDLER_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_COLLISION_HANDLER_COLLISION_InLow  in  1  collision flag from detector, 0 = collision.
- SC_COLLISION_HANDLER_FRAME_InHigh  in  1  one-clock frame tick from game timer.
- SC_COLLISION_HANDLER_START_InLow  in  1  start button, already debounced, 0 = pressed.
- SC_COLLISION_HANDLER_PLAY_OutHigh  out  1  1 = scroller may advance.
- SC_COLLISION_HANDLER_CLEAR_OutHigh  out  1  one-clock pulse that clears background rows.
- SC_COLLISION_HANDLER_BLINK_OutHigh  out  1  display blank/blink control.
- SC_COLLISION_HANDLER_GAMEOVER_OutHigh  out  1  1 while in GAMEOVER.
- SC_COLLISION_HANDLER_LIVES_OutBUS  out  LIVES_WIDTH  remaining lives.
- SC_COLLISION_HANDLER_SCORE_OutBUS  out  SCORE_WIDTH  frames survived.

Behaviour:
- All outputs are registered; no combinational input-to-output path.
- Reset (synchronous, has priority over everything, including mid-HIT or mid-GAMEOVER):
  - state = IDLE, LIVES_OutBUS = LIVES, SCORE = 0.
  - PLAY = 0, CLEAR = 0, BLINK = 0, GAMEOVER = 0, hit frame counter = 0.
  - start_prev = 1.
- Start press is a falling edge only: start_prev == 1 and START_InLow == 0. A held button produces one press. start_prev updates every cycle.
- Collision is sampled only in cycles where FRAME_InHigh = 1 and state = PLAY. The collision level in all other cycles is ignored.
- IDLE:
  - Outputs quiescent.
  - On start press: next state PLAY, LIVES = LIVES, SCORE = 0, CLEAR = 1 for exactly the first PLAY cycle.
- PLAY:
  - PLAY_OutHigh = 1.
  - On frame tick with COLLISION_InLow = 0:
    - LIVES decrements.
    - If LIVES == 1 before the decrement: next state GAMEOVER, LIVES becomes 0.
    - Otherwise: next state HIT, hit counter cleared.
    - SCORE does not increment on the hit tick.
  - On frame tick with COLLISION_InLow = 1: SCORE = SCORE + 1, saturating at all-ones (no wrap).
  - Start presses are ignored.
- HIT:
  - PLAY = 0.
  - Each frame tick toggles BLINK and increments the hit counter.
  - On the tick where the counter reaches HIT_FRAMES: next state PLAY, BLINK forced to 0, CLEAR = 1 for the first PLAY cycle.
  - Start and collision are ignored.
- GAMEOVER:
  - PLAY = 0, GAMEOVER = 1.
  - BLINK toggles on every frame tick.
  - LIVES stays at 0 and SCORE is frozen so the final score can be displayed.
  - On start press: next state PLAY, same loading as from IDLE (LIVES reload, SCORE = 0, one-cycle CLEAR), GAMEOVER = 0, BLINK = 0.
- Simultaneous events:
  - Frame tick and start press in the same cycle in GAMEOVER: start wins; that tick does not toggle BLINK.
  - Frame tick and start press in the same cycle in PLAY or HIT: start is ignored.
- Latency: every state change and output update takes effect one clock after the sampled cycle.

Test Plan:
- Reset, then START_InLow pulsed low 1 clk -> PLAY = 1 next clk, CLEAR = 1 for 1 clk, LIVES = 3, SCORE = 0.
- 5 frame ticks with COLLISION_InLow = 1, plus collision = 0 in non-tick cycles -> SCORE = 5, LIVES = 3, state remains PLAY.
- Frame tick with COLLISION_InLow = 0 -> LIVES = 2, PLAY = 0, BLINK toggles on ticks 1..3, on tick 4 BLINK = 0, PLAY = 1, CLEAR = 1 for 1 clk.
- Three consecutive hit cycles -> LIVES = 0, GAMEOVER = 1, SCORE frozen; START held low for 10 clks -> exactly one restart, LIVES = 3, SCORE = 0.
- SCORE_WIDTH = 4, 20 clean ticks -> SCORE = 15, no wrap.
- Reset asserted during HIT at hit counter = 2 -> next clk IDLE, PLAY = 0, BLINK = 0, LIVES = 3, SCORE = 0.

Source files
------------

// File: rtl/sc_collision_handler.sv
// sc_collision_handler: game-control responder for the collision line.
// Tracks lives and survival score and sequences play/hit/game-over.
module sc_collision_handler #(
    parameter int LIVES       = 3,
    parameter int LIVES_WIDTH = 2,
    parameter int SCORE_WIDTH = 8,
    parameter int HIT_FRAMES  = 4
) (
    input  logic                   SC_COLLISION_HANDLER_CLOCK_50,
    input  logic                   SC_COLLISION_HANDLER_RESET_InHigh,
    input  logic                   SC_COLLISION_HANDLER_COLLISION_InLow,
    input  logic                   SC_COLLISION_HANDLER_FRAME_InHigh,
    input  logic                   SC_COLLISION_HANDLER_START_InLow,
    output logic                   SC_COLLISION_HANDLER_PLAY_OutHigh,
    output logic                   SC_COLLISION_HANDLER_CLEAR_OutHigh,
    output logic                   SC_COLLISION_HANDLER_BLINK_OutHigh,
    output logic                   SC_COLLISION_HANDLER_GAMEOVER_OutHigh,
    output logic [LIVES_WIDTH-1:0] SC_COLLISION_HANDLER_LIVES_OutBUS,
    output logic [SCORE_WIDTH-1:0] SC_COLLISION_HANDLER_SCORE_OutBUS
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PLAY     = 2'd1;
    localparam logic [1:0] HIT      = 2'd2;
    localparam logic [1:0] GAMEOVER = 2'd3;

    // Counter must be able to hold HIT_FRAMES itself.
    localparam int HW = $clog2(HIT_FRAMES + 1);

    localparam logic [LIVES_WIDTH-1:0] LIVES_INIT = LIVES_WIDTH'(LIVES);
    localparam logic [LIVES_WIDTH-1:0] LIVES_ONE  = LIVES_WIDTH'(1);
    localparam logic [HW-1:0]          HIT_LAST   = HW'(HIT_FRAMES);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX  = {SCORE_WIDTH{1'b1}};

    logic [1:0]    state;
    logic [HW-1:0] hit_cnt;
    logic [HW-1:0] hit_next;
    logic          start_prev;
    logic          start_press;
    logic          frame;
    logic          hit;

    // Press is the falling edge of the active-low start button.
    always_comb begin
        start_press = start_prev & ~SC_COLLISION_HANDLER_START_InLow;
        frame       = SC_COLLISION_HANDLER_FRAME_InHigh;
        hit         = ~SC_COLLISION_HANDLER_COLLISION_InLow;
        hit_next    = hit_cnt + 1'b1;
    end

    // Game sequencer; every output is a register updated here.
    always_ff @(posedge SC_COLLISION_HANDLER_CLOCK_50) begin
        if (SC_COLLISION_HANDLER_RESET_InHigh) begin
            state                                 <= IDLE;
            hit_cnt                               <= '0;
            start_prev                            <= 1'b1;
            SC_COLLISION_HANDLER_PLAY_OutHigh     <= 1'b0;
            SC_COLLISION_HANDLER_CLEAR_OutHigh    <= 1'b0;
            SC_COLLISION_HANDLER_BLINK_OutHigh    <= 1'b0;
            SC_COLLISION_HANDLER_GAMEOVER_OutHigh <= 1'b0;
            SC_COLLISION_HANDLER_LIVES_OutBUS     <= LIVES_INIT;
            SC_COLLISION_HANDLER_SCORE_OutBUS     <= '0;
        end else begin
            start_prev                         <= SC_COLLISION_HANDLER_START_InLow;
            SC_COLLISION_HANDLER_CLEAR_OutHigh <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_press) begin
                        state                              <= PLAY;
                        SC_COLLISION_HANDLER_PLAY_OutHigh  <= 1'b1;
                        SC_COLLISION_HANDLER_CLEAR_OutHigh <= 1'b1;
                        SC_COLLISION_HANDLER_LIVES_OutBUS  <= LIVES_INIT;
                        SC_COLLISION_HANDLER_SCORE_OutBUS  <= '0;
                    end
                end
                PLAY: begin
                    if (frame && hit) begin
                        SC_COLLISION_HANDLER_PLAY_OutHigh <= 1'b0;
                        SC_COLLISION_HANDLER_LIVES_OutBUS <=
                            SC_COLLISION_HANDLER_LIVES_OutBUS - 1'b1;
                        if (SC_COLLISION_HANDLER_LIVES_OutBUS == LIVES_ONE) begin
                            state                                 <= GAMEOVER;
                            SC_COLLISION_HANDLER_GAMEOVER_OutHigh <= 1'b1;
                        end else begin
                            state   <= HIT;
                            hit_cnt <= '0;
                        end
                    end else if (frame) begin
                        if (SC_COLLISION_HANDLER_SCORE_OutBUS != SCORE_MAX)
                            SC_COLLISION_HANDLER_SCORE_OutBUS <=
                                SC_COLLISION_HANDLER_SCORE_OutBUS + 1'b1;
                    end
                end
                HIT: begin
                    if (frame) begin
                        hit_cnt <= hit_next;
                        if (hit_next == HIT_LAST) begin
                            state                              <= PLAY;
                            SC_COLLISION_HANDLER_PLAY_OutHigh  <= 1'b1;
                            SC_COLLISION_HANDLER_CLEAR_OutHigh <= 1'b1;
                            SC_COLLISION_HANDLER_BLINK_OutHigh <= 1'b0;
                        end else begin
                            SC_COLLISION_HANDLER_BLINK_OutHigh <=
                                ~SC_COLLISION_HANDLER_BLINK_OutHigh;
                        end
                    end
                end
                default: begin
                    // Restart beats a coincident frame tick.
                    if (start_press) begin
                        state                                 <= PLAY;
                        SC_COLLISION_HANDLER_PLAY_OutHigh     <= 1'b1;
                        SC_COLLISION_HANDLER_CLEAR_OutHigh    <= 1'b1;
                        SC_COLLISION_HANDLER_BLINK_OutHigh    <= 1'b0;
                        SC_COLLISION_HANDLER_GAMEOVER_OutHigh <= 1'b0;
                        SC_COLLISION_HANDLER_LIVES_OutBUS     <= LIVES_INIT;
                        SC_COLLISION_HANDLER_SCORE_OutBUS     <= '0;
                    end else if (frame) begin
                        SC_COLLISION_HANDLER_BLINK_OutHigh <=
                            ~SC_COLLISION_HANDLER_BLINK_OutHigh;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_collision_handler.sv
// tb_sc_collision_handler: directed vectors for sc_collision_handler.
// A second instance with a 4-bit score shares the stimulus.
module tb_sc_collision_handler;

    logic clk = 1'b0;
    logic rst, col, frm, st;
    logic play, clr, blink, go;
    logic [1:0] lives;
    logic [7:0] score;
    logic play2, clr2, blink2, go2;
    logic [1:0] lives2;
    logic [3:0] score2;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sc_collision_handler dut (
        .SC_COLLISION_HANDLER_CLOCK_50        (clk),
        .SC_COLLISION_HANDLER_RESET_InHigh    (rst),
        .SC_COLLISION_HANDLER_COLLISION_InLow (col),
        .SC_COLLISION_HANDLER_FRAME_InHigh    (frm),
        .SC_COLLISION_HANDLER_START_InLow     (st),
        .SC_COLLISION_HANDLER_PLAY_OutHigh    (play),
        .SC_COLLISION_HANDLER_CLEAR_OutHigh   (clr),
        .SC_COLLISION_HANDLER_BLINK_OutHigh   (blink),
        .SC_COLLISION_HANDLER_GAMEOVER_OutHigh(go),
        .SC_COLLISION_HANDLER_LIVES_OutBUS    (lives),
        .SC_COLLISION_HANDLER_SCORE_OutBUS    (score)
    );

    sc_collision_handler #(.SCORE_WIDTH(4)) dut4 (
        .SC_COLLISION_HANDLER_CLOCK_50        (clk),
        .SC_COLLISION_HANDLER_RESET_InHigh    (rst),
        .SC_COLLISION_HANDLER_COLLISION_InLow (col),
        .SC_COLLISION_HANDLER_FRAME_InHigh    (frm),
        .SC_COLLISION_HANDLER_START_InLow     (st),
        .SC_COLLISION_HANDLER_PLAY_OutHigh    (play2),
        .SC_COLLISION_HANDLER_CLEAR_OutHigh   (clr2),
        .SC_COLLISION_HANDLER_BLINK_OutHigh   (blink2),
        .SC_COLLISION_HANDLER_GAMEOVER_OutHigh(go2),
        .SC_COLLISION_HANDLER_LIVES_OutBUS    (lives2),
        .SC_COLLISION_HANDLER_SCORE_OutBUS    (score2)
    );

    typedef struct {
        logic rst, col, frm, st;
        logic play, clr, blink, go;
        int   lives, score;
    } vec_t;

    localparam int NV = 28;
    vec_t tbl[NV];

    function automatic vec_t mk(logic r, logic c, logic f, logic s,
                                logic p, logic cl, logic b, logic g,
                                int l, int sc);
        vec_t v;
        v.rst = r; v.col = c; v.frm = f; v.st = s;
        v.play = p; v.clr = cl; v.blink = b; v.go = g;
        v.lives = l; v.score = sc;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c,
                         input logic f, input logic s);
        rst = r; col = c; frm = f; st = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic p, input logic cl,
                           input logic b, input logic g,
                           input int l, input int sc);
        chk({nm, ".play"},  int'(play),  int'(p));
        chk({nm, ".clear"}, int'(clr),   int'(cl));
        chk({nm, ".blink"}, int'(blink), int'(b));
        chk({nm, ".gover"}, int'(go),    int'(g));
        chk({nm, ".lives"}, int'(lives), l);
        chk({nm, ".score"}, int'(score), sc);
    endtask

    int nclr;

    initial begin
        //               rst col frm st  ply clr blk go lives score
        tbl[0]  = mk(1, 1, 0, 1,  0, 0, 0, 0, 3, 0);
        tbl[1]  = mk(0, 1, 0, 0,  1, 1, 0, 0, 3, 0);
        tbl[2]  = mk(0, 1, 0, 1,  1, 0, 0, 0, 3, 0);
        tbl[3]  = mk(0, 1, 1, 1,  1, 0, 0, 0, 3, 1);
        tbl[4]  = mk(0, 0, 0, 1,  1, 0, 0, 0, 3, 1);
        tbl[5]  = mk(0, 1, 1, 1,  1, 0, 0, 0, 3, 2);
        tbl[6]  = mk(0, 1, 1, 1,  1, 0, 0, 0, 3, 3);
        tbl[7]  = mk(0, 0, 0, 1,  1, 0, 0, 0, 3, 3);
        tbl[8]  = mk(0, 1, 1, 1,  1, 0, 0, 0, 3, 4);
        tbl[9]  = mk(0, 1, 1, 1,  1, 0, 0, 0, 3, 5);
        tbl[10] = mk(0, 0, 1, 1,  0, 0, 0, 0, 2, 5);
        tbl[11] = mk(0, 0, 0, 1,  0, 0, 0, 0, 2, 5);
        tbl[12] = mk(0, 1, 1, 1,  0, 0, 1, 0, 2, 5);
        tbl[13] = mk(0, 1, 1, 0,  0, 0, 0, 0, 2, 5);
        tbl[14] = mk(0, 1, 1, 1,  0, 0, 1, 0, 2, 5);
        tbl[15] = mk(0, 1, 1, 1,  1, 1, 0, 0, 2, 5);
        tbl[16] = mk(0, 1, 0, 1,  1, 0, 0, 0, 2, 5);
        tbl[17] = mk(0, 1, 1, 1,  1, 0, 0, 0, 2, 6);
        tbl[18] = mk(0, 0, 1, 1,  0, 0, 0, 0, 1, 6);
        tbl[19] = mk(0, 0, 1, 1,  0, 0, 1, 0, 1, 6);
        tbl[20] = mk(0, 0, 1, 1,  0, 0, 0, 0, 1, 6);
        tbl[21] = mk(0, 0, 1, 1,  0, 0, 1, 0, 1, 6);
        tbl[22] = mk(0, 1, 1, 1,  1, 1, 0, 0, 1, 6);
        tbl[23] = mk(0, 0, 1, 1,  0, 0, 0, 1, 0, 6);
        tbl[24] = mk(0, 1, 1, 1,  0, 0, 1, 1, 0, 6);
        tbl[25] = mk(0, 0, 1, 1,  0, 0, 0, 1, 0, 6);
        tbl[26] = mk(0, 1, 1, 0,  1, 1, 0, 0, 3, 0);
        tbl[27] = mk(0, 1, 0, 0,  1, 0, 0, 0, 3, 0);

        rst = 1'b1; col = 1'b1; frm = 1'b0; st = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst, tbl[i].col, tbl[i].frm, tbl[i].st);
            chk_all($sformatf("vec%0d", i), tbl[i].play, tbl[i].clr,
                    tbl[i].blink, tbl[i].go, tbl[i].lives, tbl[i].score);
        end

        // Lose all lives again, then hold start for ten clocks.
        drive(0, 1, 0, 1);
        drive(0, 1, 1, 1);
        drive(0, 1, 1, 1);
        chk("seqA.score2", int'(score), 2);
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 1, 1);
            for (int j = 0; j < 4; j++) drive(0, 1, 1, 1);
            chk($sformatf("seqA.rec%0d.play", k), int'(play), 1);
            chk($sformatf("seqA.rec%0d.lives", k), int'(lives), 2 - k);
        end
        drive(0, 0, 1, 1);
        chk_all("seqA.over", 0, 0, 0, 1, 0, 2);
        for (int j = 0; j < 3; j++) drive(0, 1, 1, 1);
        chk_all("seqA.frozen", 0, 0, 1, 1, 0, 2);
        nclr = 0;
        for (int j = 0; j < 10; j++) begin
            drive(0, 1, 0, 0);
            if (clr) nclr++;
        end
        chk("seqA.clear_pulses", nclr, 1);
        chk_all("seqA.restart", 1, 0, 0, 0, 3, 0);

        // Score saturation on both widths.
        drive(0, 1, 0, 1);
        for (int j = 0; j < 20; j++) drive(0, 1, 1, 1);
        chk("seqB.score8", int'(score), 20);
        chk("seqB.score4", int'(score2), 15);
        chk("seqB.lives4", int'(lives2), 3);
        chk("seqB.play4", int'(play2), 1);

        // Reset in the middle of a hit freeze.
        drive(0, 0, 1, 1);
        chk("seqC.hit.lives", int'(lives), 2);
        drive(0, 1, 1, 1);
        drive(0, 1, 1, 1);
        chk("seqC.cnt2.blink", int'(blink), 0);
        chk("seqC.cnt2.play", int'(play), 0);
        drive(1, 1, 1, 1);
        chk_all("seqC.reset", 0, 0, 0, 0, 3, 0);
        drive(0, 0, 1, 1);
        chk_all("seqC.idle", 0, 0, 0, 0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
